spi_master_wb: RTL
==================

SPI_MASTER_WB -- requirements
Module: spi_master_wb

Interface
REQ-001 Parameter: DIV_RST, 8'h03, reset value of the DIV register (SCK half-period = DIV+1 clocks).
REQ-002 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-003 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-004 wb_addr_i  in  8  register address.
REQ-005 wb_dat_i  in  8  write data.
REQ-006 wb_dat_o  out  8  read data, valid while wb_ack_o=1.
REQ-007 wb_stb_i  in  1  access strobe.
REQ-008 wb_we_i  in  1  1=write, 0=read.
REQ-009 wb_ack_o  out  1  access acknowledge.
REQ-010 spi_sck  out  1  serial clock, CPOL=0.
REQ-011 spi_mosi  out  1  serial data out, MSB first.
REQ-012 spi_miso  in  1  serial data in.
REQ-013 spi_ss  out  1  slave select, active-low.
REQ-014 irq  out  1  level, equals STATUS.done.

Function
REQ-015 Register map: 0x00 TXD (RW); 0x01 CMD (W; reads 0x00); 0x02 RXD (R); 0x03 STATUS (R: bit0 busy, bit1 done, others 0); 0x04 DIV (RW); other addresses: writes ignored, reads 0x00, still acked.
REQ-016 Wishbone: wb_ack_o asserts the cycle after wb_stb_i=1 with wb_ack_o=0, then deasserts; one ack per strobe; write takes effect on the acked cycle; wb_dat_o registered alongside ack.
REQ-017 Write to CMD while not busy starts a frame: byte0 = written CMD value ({we, addr[6:0]}), byte1 = TXD; write to CMD while busy is acked and ignored.
REQ-018 Writes to TXD or DIV while busy are acked; new values apply to the next frame only (frame latches both at start).
REQ-019 FSM states: IDLE, SETUP, SHIFT0, GAP, SHIFT1, HOLD; h = DIV+1 clocks.
REQ-020 IDLE: spi_ss=1, spi_sck=0, spi_mosi=0; frame start -> SETUP, spi_ss=0, spi_mosi=byte0[7], busy=1.
REQ-021 SETUP lasts h clocks -> SHIFT0.
REQ-022 SHIFT0/SHIFT1: 8 bits each, every bit = h clocks SCK low then h clocks SCK high; MOSI changes only on SCK falling edge (or state entry); MISO sampled on the clock SCK rises.
REQ-023 SHIFT0 -> GAP after 8th bit's high phase; GAP: SCK low, SS low, 2h clocks, MOSI=byte1[7] -> SHIFT1.
REQ-024 SHIFT1 -> HOLD; HOLD: SCK low, h clocks -> IDLE with spi_ss=1, busy=0, done=1.
REQ-025 MISO bits of byte0 discarded; byte1 MISO bits shifted MSB first into RXD, RXD updated once at HOLD entry.
REQ-026 Frame length from CMD-write ack to spi_ss rising = 36*h clocks (+/-1 fixed); exactly 16 SCK rising edges.
REQ-027 done is sticky; cleared by RXD read ack; if frame completion and RXD read coincide, done=1 wins.
REQ-028 Bit counter 3 bits, wraps 7->0 marking byte end; half-period counter 8 bits, compares to DIV latched at frame start (DIV=0 gives h=1, DIV=255 gives h=256).

Reset
REQ-029 On wb_rst_i=1: state IDLE, spi_ss=1, spi_sck=0, spi_mosi=0, wb_ack_o=0, wb_dat_o=0, TXD=0, RXD=0, DIV=DIV_RST, busy=0, done=0, irq=0, counters 0.
REQ-030 Reset mid-frame aborts immediately with the above values next cycle; RXD not updated from the partial frame.

Structure
REQ-031 Package spi_pkg holds: FSM state enum, register address constants, STATUS bit indices, DIV_RST default.
REQ-032 One sub-module spi_sck_gen: half-period counter producing SCK level, rise and fall strobes; FSM, shift registers and Wishbone decode stay in spi_master_wb.

Verification
REQ-033 Reset then read all registers -> TXD 0x00, RXD 0x00, STATUS 0x00, DIV 0x03, ack one cycle after stb.
REQ-034 TXD=0xA5, CMD=0x81, DIV=0, slave model -> MOSI bytes 0x81,0xA5; 16 SCK rises; SS low 36 clocks; STATUS=0x02, irq=1.
REQ-035 CMD=0x00, slave drives 0x3C in byte1 -> RXD=0x3C; RXD read clears done; STATUS=0x00.
REQ-036 DIV=4, CMD written twice mid-frame -> second write ignored, single 180-clock frame, TXD change mid-frame not on MOSI.
REQ-037 Assert wb_rst_i during SHIFT1 -> next cycle SS=1, SCK=0, busy=0, done=0, RXD unchanged (0x00).
REQ-038 RXD read on the frame-completion cycle -> done remains 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the Wishbone SPI master: FSM states, register map,
// STATUS bit positions and the default SCK divider.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT0,
    ST_GAP,
    ST_SHIFT1,
    ST_HOLD
  } spiState_e;

  localparam logic [7:0] ADDR_TXD    = 8'h00;
  localparam logic [7:0] ADDR_CMD    = 8'h01;
  localparam logic [7:0] ADDR_RXD    = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h03;
  localparam logic [7:0] ADDR_DIV    = 8'h04;

  localparam logic [2:0] STATUS_BUSY_BIT = 3'd0;
  localparam logic [2:0] STATUS_DONE_BIT = 3'd1;

  localparam logic [7:0] DIV_RST_DEFAULT = 8'h03;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter: paces every FSM phase in units of DIV+1 clocks and,
// when toggling is enabled, produces the SCK level with rise/fall strobes.
module spi_sck_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       toggleEn_i,
  input  logic [7:0] div_i,
  output logic       sck_o,
  output logic       halfEnd_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;

  // Strobes fire on the clock whose edge moves SCK, so SCK and the strobe
  // consumers update together.
  always_comb begin
    halfEnd_o = en_i && (cnt_q == div_i);
    rise_o    = halfEnd_o && toggleEn_i && !sck_q;
    fall_o    = halfEnd_o && toggleEn_i && sck_q;
    cnt_d     = cnt_q + 8'd1;
    sck_d     = sck_q;
    if (!en_i) begin
      cnt_d = 8'd0;
      sck_d = 1'b0;
    end else if (halfEnd_o) begin
      cnt_d = 8'd0;
      if (toggleEn_i) begin
        sck_d = ~sck_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_master_wb.sv
// Wishbone-controlled SPI master (mode 0): sends a command byte then a data
// byte, captures the slave's reply to the data byte into RXD.
module spi_master_wb
  import spi_pkg::*;
#(
  parameter logic [7:0] DIV_RST = DIV_RST_DEFAULT
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss,
  output logic       irq
);

  spiState_e   state_q, state_d;
  logic        ack_q, ack_d;
  logic [7:0]  datOut_q, datOut_d;
  logic [7:0]  txd_q, txd_d;
  logic [7:0]  rxd_q, rxd_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  divLat_q, divLat_d;
  logic [15:0] txShift_q, txShift_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic        gapSecond_q, gapSecond_d;
  logic        done_q, done_d;

  logic        accept, wrEn, rdEn, busy, sckToggle;
  logic        halfEnd, sckRise, sckFall;
  logic [7:0]  readMux, statusReg;

  assign accept    = wb_stb_i && !ack_q;
  assign wrEn      = accept && wb_we_i;
  assign rdEn      = accept && !wb_we_i;
  assign busy      = (state_q != ST_IDLE);
  assign sckToggle = (state_q == ST_SHIFT0) || (state_q == ST_SHIFT1);

  spi_sck_gen u_sck_gen (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .en_i       (busy),
    .toggleEn_i (sckToggle),
    .div_i      (divLat_q),
    .sck_o      (spi_sck),
    .halfEnd_o  (halfEnd),
    .rise_o     (sckRise),
    .fall_o     (sckFall)
  );

  always_comb begin
    statusReg                  = 8'h00;
    statusReg[STATUS_BUSY_BIT] = busy;
    statusReg[STATUS_DONE_BIT] = done_q;
    readMux                    = 8'h00;
    case (wb_addr_i)
      ADDR_TXD:    readMux = txd_q;
      ADDR_RXD:    readMux = rxd_q;
      ADDR_STATUS: readMux = statusReg;
      ADDR_DIV:    readMux = div_q;
      default:     readMux = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = accept;
    datOut_d    = 8'h00;
    txd_d       = txd_q;
    rxd_d       = rxd_q;
    div_d       = div_q;
    divLat_d    = divLat_q;
    txShift_d   = txShift_q;
    rxShift_d   = rxShift_q;
    bitCnt_d    = bitCnt_q;
    gapSecond_d = gapSecond_q;
    done_d      = done_q;

    if (rdEn) begin
      datOut_d = readMux;
    end
    if (wrEn && (wb_addr_i == ADDR_TXD)) begin
      txd_d = wb_dat_i;
    end
    if (wrEn && (wb_addr_i == ADDR_DIV)) begin
      div_d = wb_dat_i;
    end
    if (rdEn && (wb_addr_i == ADDR_RXD)) begin
      done_d = 1'b0;
    end

    // The two bytes live in one 16-bit shifter so MOSI is always its MSB.
    case (state_q)
      ST_IDLE: begin
        if (wrEn && (wb_addr_i == ADDR_CMD)) begin
          state_d     = ST_SETUP;
          txShift_d   = {wb_dat_i, txd_q};
          divLat_d    = div_q;
          bitCnt_d    = 3'd0;
          rxShift_d   = 8'h00;
          gapSecond_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (halfEnd) begin
          state_d = ST_SHIFT0;
        end
      end
      ST_SHIFT0: begin
        if (sckFall) begin
          txShift_d = {txShift_q[14:0], 1'b0};
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d     = ST_GAP;
            gapSecond_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (halfEnd) begin
          if (gapSecond_q) begin
            state_d     = ST_SHIFT1;
            gapSecond_d = 1'b0;
          end else begin
            gapSecond_d = 1'b1;
          end
        end
      end
      ST_SHIFT1: begin
        if (sckRise) begin
          rxShift_d = {rxShift_q[6:0], spi_miso};
        end
        if (sckFall) begin
          txShift_d = {txShift_q[14:0], 1'b0};
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = ST_HOLD;
            rxd_d   = rxShift_q;
          end
        end
      end
      ST_HOLD: begin
        // Completion overrides a coincident RXD read clearing done.
        if (halfEnd) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      datOut_q    <= 8'h00;
      txd_q       <= 8'h00;
      rxd_q       <= 8'h00;
      div_q       <= DIV_RST;
      divLat_q    <= DIV_RST;
      txShift_q   <= 16'h0000;
      rxShift_q   <= 8'h00;
      bitCnt_q    <= 3'd0;
      gapSecond_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      datOut_q    <= datOut_d;
      txd_q       <= txd_d;
      rxd_q       <= rxd_d;
      div_q       <= div_d;
      divLat_q    <= divLat_d;
      txShift_q   <= txShift_d;
      rxShift_q   <= rxShift_d;
      bitCnt_q    <= bitCnt_d;
      gapSecond_q <= gapSecond_d;
      done_q      <= done_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = datOut_q;
  assign spi_ss   = !busy;
  assign spi_mosi = busy && txShift_q[15];
  assign irq      = done_q;

endmodule
